us_delay_ctrl: RTL and testbench

US_DELAY_CTRL -- requirements
Module: us_delay_ctrl

---
 rtl/us_delay_pkg.sv | 18 +
 rtl/us_delay_ctrl.sv | 154 +++++++++++++++
 tb/tb_us_delay_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/us_delay_pkg.sv
// ---------------------------------------------------------------------------
// us_delay_pkg
// Shared definitions for the microsecond delay controller: the controller
// state encoding and the default width of the microsecond count.
// ---------------------------------------------------------------------------
package us_delay_pkg;

   // Default width of the microsecond delay count (about 1 s of range).
   localparam int US_DELAY_CNT_W_DEFAULT = 20;

   // Controller states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } us_delay_state_e;

endpackage : us_delay_pkg

// File: rtl/us_delay_ctrl.sv
// ---------------------------------------------------------------------------
// us_delay_ctrl
// Microsecond delay controller. It accepts a start request with a delay
// length in microseconds, enables the upstream 1 us timer while the delay
// runs, counts its ticks down and pulses done once at expiry.
//
// Optional feature (macro US_DELAY_CTRL_RELOAD_EN):
//   Adds the periodic input. A delay started with periodic=1 reloads itself
//   from the latched length at every expiry, pulsing done each period and
//   staying busy until abort or reset.
//
// Ports:
//   clk_36MHz  in   1      sole clock, rising edge
//   reset      in   1      synchronous active-high reset
//   tick_1us   in   1      one-cycle 1 us tick from the upstream timer
//   tick_en    out  1      enables the upstream timer while a delay runs
//   start      in   1      one-cycle request to begin a delay
//   delay_us   in   CNT_W  delay length, sampled on an accepted start
//   abort      in   1      cancels a running delay
//   periodic   in   1      (RELOAD_EN only) auto-reload request, sampled with start
//   busy       out  1      delay in progress
//   done       out  1      one-cycle pulse at delay expiry
//   remaining  out  CNT_W  microseconds left in the current delay
// ---------------------------------------------------------------------------
module us_delay_ctrl
   import us_delay_pkg::*;
#(
   parameter int CNT_W = US_DELAY_CNT_W_DEFAULT
) (
   input  logic             clk_36MHz,
   input  logic             reset,
   input  logic             tick_1us,
   output logic             tick_en,
   input  logic             start,
   input  logic [CNT_W-1:0] delay_us,
   input  logic             abort,
`ifdef US_DELAY_CTRL_RELOAD_EN
   input  logic             periodic,
`endif
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   us_delay_state_e  state_q, state_d;
   logic [CNT_W-1:0] rem_q, rem_d;
`ifdef US_DELAY_CTRL_RELOAD_EN
   logic             periodic_q, periodic_d;
   logic [CNT_W-1:0] reload_q, reload_d;
   logic             pulse_q, pulse_d;
`endif

   // State and datapath registers; reset overrides every other input.
   always_ff @(posedge clk_36MHz) begin
      if (reset) begin
         state_q    <= IDLE;
         rem_q      <= CNT_ZERO;
`ifdef US_DELAY_CTRL_RELOAD_EN
         periodic_q <= 1'b0;
         reload_q   <= CNT_ZERO;
         pulse_q    <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         rem_q      <= rem_d;
`ifdef US_DELAY_CTRL_RELOAD_EN
         periodic_q <= periodic_d;
         reload_q   <= reload_d;
         pulse_q    <= pulse_d;
`endif
      end
   end

   // Next-state and countdown logic.
   always_comb begin
      state_d    = state_q;
      rem_d      = rem_q;
`ifdef US_DELAY_CTRL_RELOAD_EN
      periodic_d = periodic_q;
      reload_d   = reload_q;
      pulse_d    = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            // Abort wins over a coincident start; ticks are ignored here.
            if (start && !abort) begin
               rem_d = delay_us;
`ifdef US_DELAY_CTRL_RELOAD_EN
               periodic_d = periodic;
               reload_d   = delay_us;
`endif
               // A zero-length delay skips RUN and expires immediately.
               if (delay_us != CNT_ZERO) begin
                  state_d = RUN;
               end else begin
                  state_d = FIN;
               end
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            // Abort beats a simultaneous tick and produces no done.
            if (abort) begin
               state_d = IDLE;
               rem_d   = CNT_ZERO;
            end else if (tick_1us) begin
               // remaining is always >= 1 in RUN, so this never underflows.
               if (rem_q > CNT_ONE) begin
                  rem_d = rem_q - CNT_ONE;
               end else begin
`ifdef US_DELAY_CTRL_RELOAD_EN
                  if (periodic_q) begin
                     rem_d   = reload_q;
                     pulse_d = 1'b1;
                  end else begin
                     rem_d   = CNT_ZERO;
                     state_d = FIN;
                  end
`else
                  rem_d   = CNT_ZERO;
                  state_d = FIN;
`endif
               end
            end else begin
               rem_d = rem_q;
            end
         end
         FIN: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            rem_d   = CNT_ZERO;
         end
      endcase
   end

   // Outputs decode registered state only, so they are glitch-free.
   always_comb begin
      busy      = (state_q == RUN);
      tick_en   = (state_q == RUN);
      remaining = rem_q;
`ifdef US_DELAY_CTRL_RELOAD_EN
      done      = (state_q == FIN) || pulse_q;
`else
      done      = (state_q == FIN);
`endif
   end

endmodule : us_delay_ctrl

// File: tb/tb_us_delay_ctrl.sv
// ---------------------------------------------------------------------------
// tb_us_delay_ctrl
// Directed self-checking bench for us_delay_ctrl. Inputs change 1 ns after a
// rising edge and outputs are checked at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_us_delay_ctrl;

   localparam int CNT_W = 20;

   logic             clk_36MHz = 1'b0;
   logic             reset;
   logic             tick_1us;
   logic             tick_en;
   logic             start;
   logic [CNT_W-1:0] delay_us;
   logic             abort;
`ifdef US_DELAY_CTRL_RELOAD_EN
   logic             periodic;
`endif
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] remaining;

   int checks = 0;
   int errors = 0;

   us_delay_ctrl #(.CNT_W(CNT_W)) dut (
      .clk_36MHz (clk_36MHz),
      .reset     (reset),
      .tick_1us  (tick_1us),
      .tick_en   (tick_en),
      .start     (start),
      .delay_us  (delay_us),
      .abort     (abort),
`ifdef US_DELAY_CTRL_RELOAD_EN
      .periodic  (periodic),
`endif
      .busy      (busy),
      .done      (done),
      .remaining (remaining)
   );

   always #14 clk_36MHz = ~clk_36MHz;

   task automatic cyc();
      @(posedge clk_36MHz);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_out(input string tag, input logic b, input logic te,
                          input logic d, input logic [31:0] rem);
      chk({tag, ".busy"}, {31'd0, busy}, {31'd0, b});
      chk({tag, ".tick_en"}, {31'd0, tick_en}, {31'd0, te});
      chk({tag, ".done"}, {31'd0, done}, {31'd0, d});
      chk({tag, ".remaining"}, {12'd0, remaining}, rem);
   endtask

   initial begin
      reset    = 1'b1;
      tick_1us = 1'b0;
      start    = 1'b0;
      delay_us = 20'd0;
      abort    = 1'b0;
`ifdef US_DELAY_CTRL_RELOAD_EN
      periodic = 1'b0;
`endif
      cyc();
      cyc();
      chk_out("reset", 1'b0, 1'b0, 1'b0, 32'd0);
      reset = 1'b0;
      cyc();

      // delay 5: counts 5..0, done one cycle after the 5th tick
      start = 1'b1; delay_us = 20'd5;
      cyc();
      start = 1'b0; delay_us = 20'd0;
      chk_out("d5.start", 1'b1, 1'b1, 1'b0, 32'd5);
      cyc();
      chk_out("d5.notick", 1'b1, 1'b1, 1'b0, 32'd5);
      for (int k = 1; k <= 4; k++) begin
         tick_1us = 1'b1; cyc(); tick_1us = 1'b0;
         chk_out("d5.tick", 1'b1, 1'b1, 1'b0, 32'(5 - k));
      end
      tick_1us = 1'b1; cyc(); tick_1us = 1'b0;
      chk_out("d5.expire", 1'b0, 1'b0, 1'b1, 32'd0);
      cyc();
      chk_out("d5.idle", 1'b0, 1'b0, 1'b0, 32'd0);

      // ticks in IDLE are ignored
      tick_1us = 1'b1; cyc(); tick_1us = 1'b0;
      chk_out("idle.tick", 1'b0, 1'b0, 1'b0, 32'd0);

      // delay 0: done one cycle later, never busy
      start = 1'b1; delay_us = 20'd0;
      cyc();
      start = 1'b0;
      chk_out("d0.fin", 1'b0, 1'b0, 1'b1, 32'd0);
      cyc();
      chk_out("d0.idle", 1'b0, 1'b0, 1'b0, 32'd0);

      // delay 10 aborted on the 4th tick
      start = 1'b1; delay_us = 20'd10;
      cyc();
      start = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         tick_1us = 1'b1; cyc(); tick_1us = 1'b0;
      end
      chk_out("abort.pre", 1'b1, 1'b1, 1'b0, 32'd7);
      abort = 1'b1; tick_1us = 1'b1;
      cyc();
      abort = 1'b0; tick_1us = 1'b0;
      chk_out("abort.now", 1'b0, 1'b0, 1'b0, 32'd0);
      cyc();
      chk_out("abort.after", 1'b0, 1'b0, 1'b0, 32'd0);

      // abort and start together in IDLE: nothing accepted
      start = 1'b1; abort = 1'b1; delay_us = 20'd3;
      cyc();
      start = 1'b0; abort = 1'b0;
      chk_out("abort_start", 1'b0, 1'b0, 1'b0, 32'd0);

      // second start during RUN is ignored
      start = 1'b1; delay_us = 20'd4;
      cyc();
      start = 1'b0;
      tick_1us = 1'b1; cyc(); tick_1us = 1'b0;
      chk_out("restart.t1", 1'b1, 1'b1, 1'b0, 32'd3);
      start = 1'b1; delay_us = 20'd2;
      cyc();
      start = 1'b0;
      chk_out("restart.ign", 1'b1, 1'b1, 1'b0, 32'd3);
      tick_1us = 1'b1; cyc(); cyc(); tick_1us = 1'b0;
      chk_out("restart.t3", 1'b1, 1'b1, 1'b0, 32'd1);
      tick_1us = 1'b1; cyc(); tick_1us = 1'b0;
      chk_out("restart.t4", 1'b0, 1'b0, 1'b1, 32'd0);
      cyc();

      // reset mid-RUN at remaining 7, together with start and tick
      start = 1'b1; delay_us = 20'd9;
      cyc();
      start = 1'b0;
      tick_1us = 1'b1; cyc(); cyc(); tick_1us = 1'b0;
      chk_out("rst.pre", 1'b1, 1'b1, 1'b0, 32'd7);
      reset = 1'b1; start = 1'b1; tick_1us = 1'b1; delay_us = 20'd6;
      cyc();
      reset = 1'b0; start = 1'b0; tick_1us = 1'b0;
      chk_out("rst.now", 1'b0, 1'b0, 1'b0, 32'd0);
      cyc();
      chk_out("rst.after", 1'b0, 1'b0, 1'b0, 32'd0);
      start = 1'b1; delay_us = 20'd1;
      cyc();
      start = 1'b0;
      chk_out("rst.restart", 1'b1, 1'b1, 1'b0, 32'd1);
      tick_1us = 1'b1; cyc(); tick_1us = 1'b0;
      chk_out("rst.expire", 1'b0, 1'b0, 1'b1, 32'd0);
      cyc();

`ifdef US_DELAY_CTRL_RELOAD_EN
      // periodic delay 3 for 4 periods, then abort
      start = 1'b1; periodic = 1'b1; delay_us = 20'd3;
      cyc();
      start = 1'b0; periodic = 1'b0; delay_us = 20'd0;
      chk_out("per.start", 1'b1, 1'b1, 1'b0, 32'd3);
      for (int p = 0; p < 4; p++) begin
         for (int t = 1; t <= 3; t++) begin
            tick_1us = 1'b1; cyc(); tick_1us = 1'b0;
            if (t == 3) chk_out("per.expire", 1'b1, 1'b1, 1'b1, 32'd3);
            else        chk_out("per.tick", 1'b1, 1'b1, 1'b0, 32'(3 - t));
         end
      end
      cyc();
      chk_out("per.gap", 1'b1, 1'b1, 1'b0, 32'd3);
      abort = 1'b1;
      cyc();
      abort = 1'b0;
      chk_out("per.abort", 1'b0, 1'b0, 1'b0, 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_us_delay_ctrl
